// File: rtl/riscv_crypto_fu_pkg.sv
// Shared constants for the crypto functional unit result path.
// Holds the destination-tag width and the legal XLEN / DEPTH values.
package riscv_crypto_fu_pkg;

    localparam int unsigned TAG_W   = 5;
    localparam int unsigned XLEN_32 = 32;
    localparam int unsigned XLEN_64 = 64;
    localparam int unsigned DEPTH_2 = 2;
    localparam int unsigned DEPTH_4 = 4;

    // True when the (xlen, depth) pair is a supported configuration.
    function automatic logic legal_cfg(input int unsigned xlen, input int unsigned depth);
        return ((xlen == XLEN_32) || (xlen == XLEN_64)) &&
               ((depth == DEPTH_2) || (depth == DEPTH_4));
    endfunction

endpackage

// File: rtl/riscv_crypto_fu_result_q_if.sv
// Handshake bundle between the crypto FU, its result queue and writeback.
// master: the upstream/writeback side (drives in_*, out_ready, flush).
// slave : the result queue (drives in_ready, out_*, count).
interface riscv_crypto_fu_result_q_if
    import riscv_crypto_fu_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_rd;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_rd;
    logic [TAG_W-1:0]  out_tag;
    logic [CNT_W-1:0]  count;

    modport master (
        output flush, in_valid, in_rd, in_tag, out_ready,
        input  in_ready, out_valid, out_rd, out_tag, count
    );

    modport slave (
        input  flush, in_valid, in_rd, in_tag, out_ready,
        output in_ready, out_valid, out_rd, out_tag, count
    );

endinterface

// File: rtl/riscv_crypto_fu_result_q.sv
// Small FIFO that buffers crypto FU results ahead of writeback.
// Ports: g_clk/g_reset (async, active-high); flush drops everything;
// in_valid/in_ready/in_rd/in_tag from the FU; out_valid/out_ready/out_rd/
// out_tag toward writeback; count = occupied entries.
// Beats targeting x0 (in_tag == 0) complete the handshake but are not stored.
// in_ready and out_* depend on registered state only, so there is no
// input-to-output bypass and no out_ready -> in_ready path.
module riscv_crypto_fu_result_q
    import riscv_crypto_fu_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              g_clk,
    input  logic              g_reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_rd,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rd,
    output logic [TAG_W-1:0]  out_tag,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [XLEN-1:0]  mem_rd  [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    // Status derived from the registered occupancy only.
    assign in_ready  = (cnt != CNT_W'(DEPTH));
    assign out_valid = (cnt != '0);
    assign count     = cnt;

    assign push = in_valid && in_ready && !flush && (in_tag != '0);
    assign pop  = out_valid && out_ready && !flush;

    // Head is zero-gated so unreset storage never leaks out.
    assign out_rd  = out_valid ? mem_rd[rd_ptr]  : '0;
    assign out_tag = out_valid ? mem_tag[rd_ptr] : '0;

    // Pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents are unobservable until written.
    always_ff @(posedge g_clk) begin
        if (push) begin
            mem_rd[wr_ptr]  <= in_rd;
            mem_tag[wr_ptr] <= in_tag;
        end
    end

endmodule

// File: tb/tb_riscv_crypto_fu_result_q.sv
// Scoreboard bench for riscv_crypto_fu_result_q (XLEN=64, DEPTH=2).
module tb_riscv_crypto_fu_result_q;
    import riscv_crypto_fu_pkg::*;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [XLEN-1:0]  rd;
        logic [TAG_W-1:0] tag;
    } beat_t;

    logic clk;
    logic g_reset;

    riscv_crypto_fu_result_q_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    riscv_crypto_fu_result_q #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .g_clk     (clk),
        .g_reset   (g_reset),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_rd     (bus.in_rd),
        .in_tag    (bus.in_tag),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_rd    (bus.out_rd),
        .out_tag   (bus.out_tag),
        .count     (bus.count)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t exp_q[$];
    bit    seen9 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: samples at the falling edge, models the next rising edge.
    always @(negedge clk) begin
        logic exp_ready;
        if (g_reset) begin
            exp_q.delete();
            chk("rst_count", 64'(bus.count), 64'd0);
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        end else begin
            exp_ready = (exp_q.size() != DEPTH);
            if (bus.out_valid && bus.out_tag == 5'd9) seen9 = 1'b1;
            chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
            chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
            chk("count", 64'(bus.count), 64'(exp_q.size()));
            if (exp_q.size() != 0) begin
                chk("head_rd", bus.out_rd, exp_q[0].rd);
                chk("head_tag", 64'(bus.out_tag), 64'(exp_q[0].tag));
            end else begin
                chk("idle_rd_zero", bus.out_rd, 64'd0);
                chk("idle_tag_zero", 64'(bus.out_tag), 64'd0);
            end
            if (bus.flush) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
                if (bus.in_valid && exp_ready && bus.in_tag != '0)
                    exp_q.push_back('{rd: bus.in_rd, tag: bus.in_tag});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until the queue accepts it.
    task automatic push_wait(input logic [63:0] rd, input logic [4:0] tag);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_rd    = rd;
        bus.in_tag   = tag;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("push_accepted", 64'(ok), 64'd1);
        cyc();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        g_reset       = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_rd     = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        #3;
        chk("por_count", 64'(bus.count), 64'd0);
        chk("por_in_ready", 64'(bus.in_ready), 64'd1);
        chk("por_out_valid", 64'(bus.out_valid), 64'd0);
        chk("por_out_rd", bus.out_rd, 64'd0);
        chk("por_out_tag", 64'(bus.out_tag), 64'd0);
        cyc();
        cyc();
        g_reset = 1'b0;
        cyc();

        // Single push, appears next cycle.
        push_wait(64'h0123456789ABCDEF, 5'd7);
        chk("single_count", 64'(bus.count), 64'd1);
        chk("single_rd", bus.out_rd, 64'h0123456789ABCDEF);
        chk("single_tag", 64'(bus.out_tag), 64'd7);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        cyc();

        // Fill, back-pressure, then drain in order.
        push_wait(64'h11, 5'd1);
        push_wait(64'h22, 5'd2);
        chk("full_count", 64'(bus.count), 64'd2);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_rd    = 64'h33;
        bus.in_tag   = 5'd3;
        cyc();
        cyc();
        chk("held_count", 64'(bus.count), 64'd2);
        chk("held_head_tag", 64'(bus.out_tag), 64'd1);
        bus.out_ready = 1'b1;
        push_wait(64'h33, 5'd3);
        repeat (4) cyc();

        // Streaming: one in, one out per cycle.
        for (int t = 1; t <= 8; t++) begin
            bus.in_valid = 1'b1;
            bus.in_rd    = 64'(t) * 64'h111;
            bus.in_tag   = 5'(t);
            cyc();
        end
        bus.in_valid = 1'b0;
        repeat (3) cyc();
        bus.out_ready = 1'b0;

        // Write to x0 is consumed but not stored.
        bus.in_valid = 1'b1;
        bus.in_rd    = 64'hFFFF;
        bus.in_tag   = 5'd0;
        cyc();
        bus.in_valid = 1'b0;
        chk("x0_count", 64'(bus.count), 64'd0);
        chk("x0_out_valid", 64'(bus.out_valid), 64'd0);
        cyc();

        // Flush with a concurrent push.
        push_wait(64'hA1, 5'd4);
        push_wait(64'hA2, 5'd5);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_rd    = 64'h99;
        bus.in_tag   = 5'd9;
        cyc();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        repeat (3) cyc();
        bus.out_ready = 1'b0;

        // Asynchronous reset between edges with one entry queued.
        push_wait(64'hBEEF, 5'd11);
        @(negedge clk);
        #2;
        g_reset = 1'b1;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_out_rd", bus.out_rd, 64'd0);
        chk("arst_out_tag", 64'(bus.out_tag), 64'd0);
        chk("arst_count", 64'(bus.count), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        exp_q.delete();
        cyc();
        // Release reset and present a beat together; the next edge takes it.
        g_reset      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_rd    = 64'hC0DE;
        bus.in_tag   = 5'd12;
        cyc();
        bus.in_valid = 1'b0;
        chk("post_rst_count", 64'(bus.count), 64'd1);
        chk("post_rst_tag", 64'(bus.out_tag), 64'd12);
        bus.out_ready = 1'b1;
        repeat (3) cyc();

        chk("tag9_never_out", 64'(seen9), 64'd0);
        chk("final_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
